// File: rtl/mitchell_antilog_pipe.sv
// Mitchell antilog pipeline: adds two log-domain operands and converts the sum back to a linear product.
// Optional build macro MBM_BIAS_COMP_EN adds a saturating fraction bias correction (minimally biased variant).
module mitchell_antilog_pipe #(
   parameter int CHAR_W    = 3,
   parameter int FRAC_W    = 7,
   parameter int OUT_W     = 16,
   parameter int BIAS_CORR = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CHAR_W-1:0] a_char,
   input  logic [FRAC_W-1:0] a_frac,
   input  logic              a_zero,
   input  logic [CHAR_W-1:0] b_char,
   input  logic [FRAC_W-1:0] b_frac,
   input  logic              b_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  product
);

   localparam int EW = CHAR_W + 1;
   localparam int MW = FRAC_W + 1;
   localparam int PW = OUT_W + FRAC_W;

   if ((OUT_W != 2 * (1 << CHAR_W)) || (FRAC_W != (1 << CHAR_W) - 1) || (BIAS_CORR < 0)) begin : g_param_check
      $error("mitchell_antilog_pipe: inconsistent CHAR_W/FRAC_W/OUT_W/BIAS_CORR");
   end

   logic           en_s;
   logic [EW-1:0]  k_d, k_q;
   logic [MW-1:0]  s_d, s_q;
   logic           z1_d, z1_q, v1_q;
   logic [EW-1:0]  e_d, e_q;
   logic [MW-1:0]  m_d, m_q;
   logic           z2_q, v2_q;
   logic [OUT_W-1:0] product_d, product_q;
   logic           out_valid_q;
   logic           c_s;
   logic [FRAC_W-1:0] f_s, f_adj_s;
   logic [PW-1:0]  wide_s;
`ifdef MBM_BIAS_COMP_EN
   localparam logic [MW-1:0] BIAS_V = MW'(BIAS_CORR);
   logic [MW-1:0]  f_sum_s;
`endif

   // Global stall: every stage advances only when the output slot is free or draining.
   assign en_s      = ~out_valid_q | out_ready;
   assign in_ready  = en_s;
   assign out_valid = out_valid_q;
   assign product   = product_q;

   // Stage 1 operands: log-domain characteristic and fraction sums.
   always_comb begin
      k_d  = {1'b0, a_char} + {1'b0, b_char};
      s_d  = {1'b0, a_frac} + {1'b0, b_frac};
      z1_d = a_zero | b_zero;
   end

   // Stage 2: fold fraction carry into the exponent, rebuild the mantissa with its hidden one.
   always_comb begin
      c_s = s_q[FRAC_W];
      f_s = s_q[FRAC_W-1:0];
      e_d = k_q + {{CHAR_W{1'b0}}, c_s};
`ifdef MBM_BIAS_COMP_EN
      f_sum_s = {1'b0, f_s} + BIAS_V;
      if (f_sum_s[FRAC_W]) begin
         f_adj_s = {FRAC_W{1'b1}};
      end else begin
         f_adj_s = f_sum_s[FRAC_W-1:0];
      end
`else
      f_adj_s = f_s;
`endif
      m_d = {1'b1, f_adj_s};
   end

   // Stage 3: antilog by shifting the mantissa, then drop the fraction bits (floor).
   always_comb begin
      wide_s = PW'(m_q) << e_q;
      if (z2_q) begin
         product_d = {OUT_W{1'b0}};
      end else begin
         product_d = wide_s[PW-1:FRAC_W];
      end
   end

   // Pipeline registers; all stages, bubbles included, hold together on stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q         <= {EW{1'b0}};
         s_q         <= {MW{1'b0}};
         z1_q        <= 1'b0;
         v1_q        <= 1'b0;
         e_q         <= {EW{1'b0}};
         m_q         <= {MW{1'b0}};
         z2_q        <= 1'b0;
         v2_q        <= 1'b0;
         product_q   <= {OUT_W{1'b0}};
         out_valid_q <= 1'b0;
      end else if (en_s) begin
         k_q         <= k_d;
         s_q         <= s_d;
         z1_q        <= z1_d;
         v1_q        <= in_valid;
         e_q         <= e_d;
         m_q         <= m_d;
         z2_q        <= z1_q;
         v2_q        <= v1_q;
         product_q   <= product_d;
         out_valid_q <= v2_q;
      end else begin
         k_q         <= k_q;
         s_q         <= s_q;
         z1_q        <= z1_q;
         v1_q        <= v1_q;
         e_q         <= e_q;
         m_q         <= m_q;
         z2_q        <= z2_q;
         v2_q        <= v2_q;
         product_q   <= product_q;
         out_valid_q <= out_valid_q;
      end
   end

endmodule

// File: tb/tb_mitchell_antilog_pipe.sv
// Directed bench for mitchell_antilog_pipe: hand-computed Mitchell products, stall stream and async reset.
module tb_mitchell_antilog_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  a_char;
   logic [6:0]  a_frac;
   logic        a_zero;
   logic [2:0]  b_char;
   logic [6:0]  b_frac;
   logic        b_zero;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;

   int total = 0;
   int bad   = 0;

   // Stream vectors: A=12*B=10, 3*3 (carry), 16*8 (exact), 255*255, A zero, 2*1.
   int ska[6] = '{3, 1, 4, 7, 5, 1};
   int sxa[6] = '{64, 64, 0, 127, 99, 0};
   int sza[6] = '{0, 0, 0, 0, 1, 0};
   int skb[6] = '{3, 1, 3, 7, 2, 0};
   int sxb[6] = '{32, 64, 0, 127, 10, 0};
`ifdef MBM_BIAS_COMP_EN
   int sexp[6] = '{117, 8, 139, 65280, 0, 2};
`else
   int sexp[6] = '{112, 8, 128, 65024, 0, 2};
`endif

   mitchell_antilog_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_char    (a_char),
      .a_frac    (a_frac),
      .a_zero    (a_zero),
      .b_char    (b_char),
      .b_frac    (b_frac),
      .b_zero    (b_zero),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic set_in(input logic v, input int ka, input int xa, input int za,
                         input int kb, input int xb, input int zb);
      in_valid = v;
      a_char   = 3'(ka);
      a_frac   = 7'(xa);
      a_zero   = (za != 0);
      b_char   = 3'(kb);
      b_frac   = 7'(xb);
      b_zero   = (zb != 0);
   endtask

   // Entered 1 time unit after a rising edge; checks exact 3-cycle latency of one item.
   task automatic single(input string tag, input int ka, input int xa, input int za,
                         input int kb, input int xb, input int zb, input int expv);
      out_ready = 1'b1;
      set_in(1'b1, ka, xa, za, kb, xb, zb);
      #1;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_product"}, 32'(product), 32'(expv));
   endtask

   initial begin
      int  idx;
      int  got;
      logic acc;
      logic xfer;

      rst       = 1'b1;
      out_ready = 1'b0;
      set_in(1'b0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_product", 32'(product), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed single transfers.
`ifdef MBM_BIAS_COMP_EN
      single("a12_b10", 3, 64, 0, 3, 32, 0, 117);
`else
      single("a12_b10", 3, 64, 0, 3, 32, 0, 112);
`endif
      single("a3_b3_carry", 1, 64, 0, 1, 64, 0, 8);
`ifdef MBM_BIAS_COMP_EN
      single("a16_b8", 4, 0, 0, 3, 0, 0, 139);
      single("a255_b255", 7, 127, 0, 7, 127, 0, 65280);
`else
      single("a16_b8_exact", 4, 0, 0, 3, 0, 0, 128);
      single("a255_b255", 7, 127, 0, 7, 127, 0, 65024);
`endif
      single("a_zero", 6, 100, 1, 7, 127, 0, 0);
      single("b_zero", 7, 127, 0, 2, 5, 1, 0);
      @(posedge clk); #1;
      chk("drain_idle", 32'(out_valid), 32'd0);

      // Back-to-back stream with out_ready low in cycles 4..6.
      idx = 0;
      got = 0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         out_ready = !(cyc >= 4 && cyc <= 6);
         if (idx < 6) begin
            set_in(1'b1, ska[idx], sxa[idx], sza[idx], skb[idx], sxb[idx], 0);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         chk("stream_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
         if (cyc >= 4 && cyc <= 6) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_product", 32'(product), 32'(sexp[1]));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
         end
         acc  = in_valid && in_ready;
         xfer = out_valid && out_ready;
         if (xfer) begin
            chk($sformatf("stream_product_%0d", got), 32'(product), 32'(sexp[got]));
            got++;
         end
         @(posedge clk); #1;
         if (acc) idx++;
      end
      in_valid = 1'b0;
      chk("stream_results", 32'(got), 32'd6);
      chk("stream_accepted", 32'(idx), 32'd6);
      #1;
      chk("stream_no_dup", 32'(out_valid), 32'd0);

      // Async reset with three items in flight.
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         set_in(1'b1, ska[j], sxa[j], sza[j], skb[j], sxb[j], 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_product", 32'(product), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
         chk("post_rst_idle", 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end
`ifdef MBM_BIAS_COMP_EN
      single("post_rst", 3, 64, 0, 3, 32, 0, 117);
`else
      single("post_rst", 3, 64, 0, 3, 32, 0, 112);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mitchell_antilog_pipe.md
Name: mitchell_antilog_pipe

Overview:
Downstream consumer of the log-domain operand stage in the Mitchell multiplier datapath. Takes two operands already in log form (characteristic from the leading-one detector, 7-bit fraction from the normalising shifter), adds them in the log domain and converts the sum back to a linear product.
- 3-stage pipeline with a valid/ready handshake on both sides.
- Delivers the approximate 16-bit product of two 8-bit unsigned operands.

Parameters:
CHAR_W, 3, characteristic width; operand width is 2^CHAR_W = 8
FRAC_W, 7, fraction width (CHAR_W's operand width minus 1)
OUT_W, 16, product width; must equal 2*2^CHAR_W
BIAS_CORR, 11, fraction correction in units of 2^-FRAC_W; used only with MBM_BIAS_COMP_EN

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts operands this cycle
a_char  input  CHAR_W  characteristic k1 of operand A (leading-one position)
a_frac  input  FRAC_W  fraction x1 of A (bits below leading one, MSB-aligned)
a_zero  input  1  operand A is zero (a_char/a_frac ignored)
b_char  input  CHAR_W  characteristic k2 of B
b_frac  input  FRAC_W  fraction x2 of B
b_zero  input  1  operand B is zero
out_valid  output  1  product valid
out_ready  input  1  downstream accepts product
product  output  OUT_W  approximate product

Behaviour:
- Reset (async assert, sync-safe release): all stage valid bits 0, out_valid=0, product=0, all internal registers 0. Reset mid-operation discards every in-flight item; no output is produced for it.
- Global stall: en = ~out_valid | out_ready. in_ready = en (combinational). When en=1 all three stages advance together; when en=0 all stages hold, including bubbles. Bubbles are not collapsed.
- Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
- Latency: 3 cycles from input transfer to out_valid when no stall. Throughput 1 result/cycle.
- Stage 1 (register on en):
  - K = k1+k2, CHAR_W+1 bits.
  - S = x1+x2, FRAC_W+1 bits.
  - z = a_zero | b_zero.
  - v1 = in_valid.
- Stage 2:
  - Carry c = S[FRAC_W]; f = S[FRAC_W-1:0].
  - E = K + c (range 0..15, CHAR_W+1 bits).
  - Mantissa M = {1'b1, f}, FRAC_W+1 bits.
  - v2 = v1; z carried forward.
- Stage 3:
  - product = z ? 0 : (M << E) >> FRAC_W, computed at OUT_W+FRAC_W internal width, then truncated (floor). No rounding.
  - out_valid = v2.
- Range: the maximum result is E=15, M=255, giving 65280. This fits OUT_W, so no saturation logic is needed.
- Boundary cases:
  - E < FRAC_W: low mantissa bits are truncated.
  - Both fractions 0: the result is exact (power of two).
  - S exactly 2^FRAC_W: c=1, f=0.
- out_valid high with out_ready low: product and out_valid stay stable until the transfer.
- An input offered while in_ready=0 is not captured. The source must hold it.

Optional Feature:
MBM_BIAS_COMP_EN
- Defined: in Stage 2 the fraction becomes f' = min(f + BIAS_CORR, 2^FRAC_W - 1), a saturating add, and M = {1'b1, f'}. The carry decision still uses the uncorrected S. This reduces Mitchell's always-negative error (minimally biased variant).
- Undefined: no correction logic is present; M = {1'b1, f}.
- Latency and handshake are identical in both builds.

Test Plan:
- A=12 (k=3, x=64), B=10 (k=3, x=32), out_ready=1 -> product=112 exactly 3 cycles after transfer; with MBM_BIAS_COMP_EN -> 117.
- A=B=3 (k=1, x=64 each): carry path, E=3, M=128 -> product=8; A=16 (k=4, x=0), B=8 (k=3, x=0) -> product=128 (exact).
- A=B=255 (k=7, x=127) -> product=65024; with MBM_BIAS_COMP_EN f saturates at 127 -> 65280.
- a_zero=1 with any B -> product=0.
- Stream of 6 back-to-back pairs with out_ready low for cycles 4-6:
  - in_ready low exactly while out_valid & ~out_ready.
  - No result lost or duplicated; results appear in order.
- Assert rst for 1 cycle with 3 items in flight -> out_valid=0 and product=0 immediately (async). No stale result after release. The next input yields a correct result 3 cycles later.
